// File: rtl/seg7_pkg.sv
// Shared constants and the scan FSM state type for the 7-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/BinaryTo7Seg.sv
// Hex nibble to common-anode 7-segment pattern (active-low, bit 6 = a ... bit 0 = g).
module BinaryTo7Seg
  import seg7_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  // Pure lookup from nibble to segment pattern
  always_comb begin
    seg = SEG_BLANK;
    case (bin)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_slot_timer.sv
// Digit slot timer: counts clocks within one slot (guard interval followed by show interval).
module seg7_slot_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Slot position counter; held at zero while the scanner is idle so every slot starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign blank_done = run && (cnt == BLANK_LAST);
  assign slot_done  = run && (cnt == LAST_CNT);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with a
// ghosting guard, leading-zero blanking and a frame-synchronous load port.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

  scan_state_t state, next_state;
  logic [IW-1:0] idx, next_idx;
  logic [4*NUM_DIGITS-1:0] active_value, shadow_value, upper_digits;
  logic [NUM_DIGITS-1:0] active_dp, shadow_dp, an_sel;
  logic shadow_full, accept, transfer, boundary;
  logic blank_done, slot_done, show, lz_hide;
  logic [3:0] nibble;
  logic [6:0] dec_seg;

  seg7_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state != IDLE),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  BinaryTo7Seg u_dec (
    .bin(nibble),
    .seg(dec_seg)
  );

  // State and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // Scan sequencing: guard, show, advance digit; dropping enable always returns to idle
  always_comb begin
    next_state = state;
    next_idx   = idx;
    boundary   = 1'b0;
    case (state)
      IDLE: begin
        next_idx = '0;
        if (enable) next_state = BLANK;
      end
      BLANK: begin
        if (blank_done) next_state = SHOW;
      end
      SHOW: begin
        if (slot_done) begin
          next_state = BLANK;
          if (idx == LAST_IDX) begin
            next_idx = '0;
            boundary = 1'b1;
          end else begin
            next_idx = idx + IW'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (!enable) begin
      next_state = IDLE;
      next_idx   = '0;
      boundary   = 1'b0;
    end
  end

  assign load_ready = ~shadow_full;
  assign accept     = load_valid && !shadow_full;
  assign transfer   = shadow_full && (state == IDLE || !enable || boundary);

  // Shadow capture on handshake; promotion to the active value only at tear-free points
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_full  <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
    end else if (accept) begin
      shadow_value <= value_in;
      shadow_dp    <= dp_in;
      shadow_full  <= 1'b1;
    end else if (transfer) begin
      active_value <= shadow_value;
      active_dp    <= shadow_dp;
      shadow_full  <= 1'b0;
    end
  end

  // Select the current digit's nibble and decide whether it is a blanked leading zero
  always_comb begin
    upper_digits = active_value >> {idx, 2'b00};
    nibble       = upper_digits[3:0];
    lz_hide      = lz_blank_en && (idx != '0) && (upper_digits == '0);
    show         = (state == SHOW) && enable;
    an_sel       = AN_ALL_OFF;
    an_sel[idx]  = 1'b0;
  end

  // Registered pin drivers; blanked leading zeros still strobe their anode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_out     <= AN_ALL_OFF;
      seg_out    <= SEG_BLANK;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_out     <= show ? an_sel : AN_ALL_OFF;
      seg_out    <= (show && !lz_hide) ? dec_seg : SEG_BLANK;
      dp_out     <= show ? ~active_dp[idx] : 1'b1;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 8-clock slots, 2-clock guard).
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  logic        clk = 1'b0;
  logic        rst_n, enable, lz_blank_en, load_valid;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_ready, dp_out, frame_tick;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .lz_blank_en(lz_blank_en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  // Expected {an, seg, dp, frame_tick} t clocks after the edge that sees enable rise.
  // Slot timeline: each digit gets R clocks, the first B dark; pins lag by one clock.
  function automatic logic [12:0] ref_pins(int t, logic [15:0] v, logic [3:0] dpv, logic lz);
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, tick;
    logic [15:0] upper;
    int p, d;
    an   = 4'hF;
    seg  = 7'h7F;
    dp   = 1'b1;
    tick = (t > 0) && (t % FRAME == 0);
    if (t > 0) begin
      p = (t - 1) % R;
      d = ((t - 1) / R) % N;
      if (p >= B) begin
        upper = v >> (4 * d);
        an[d] = 1'b0;
        dp    = ~dpv[d];
        seg   = (lz && d > 0 && upper == 16'h0) ? 7'h7F : seg_tab[upper[3:0]];
      end
    end
    return {an, seg, dp, tick};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [15:0] v, input logic [3:0] d);
    value_in   = v;
    dp_in      = d;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; lz_blank_en = 1'b0; load_valid = 1'b0;
    value_in = '0; dp_in = '0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({an_out, seg_out, dp_out, frame_tick, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      $display("[TB] FAIL reset_async got %b want %b", {an_out, seg_out, dp_out, frame_tick, load_ready},
               {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end else pass_cnt++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
        $display("[TB] FAIL reset_hold i=%0d got %b want %b", i,
                 {an_out, seg_out, dp_out, frame_tick, load_ready}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
      end else pass_cnt++;
    end
  endtask

  task automatic test_hex_pattern();
    logic [12:0] exp;
    lz_blank_en = 1'b0;
    value_in = 16'h12AF; dp_in = 4'h0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if (load_ready !== 1'b0) begin
      $display("[TB] FAIL hex_ready_drop got %b want 0", load_ready);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (load_ready !== 1'b1) begin
      $display("[TB] FAIL hex_ready_rise got %b want 1", load_ready);
    end else pass_cnt++;
    enable = 1'b1;
    for (int t = 0; t <= 2 * FRAME + 2; t++) begin
      step();
      exp = ref_pins(t, 16'h12AF, 4'h0, 1'b0);
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
        $display("[TB] FAIL hex_pins t=%0d got %b want %b", t, {an_out, seg_out, dp_out, frame_tick}, exp);
      end else pass_cnt++;
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_lz_blank();
    logic [12:0] exp;
    logic [15:0] vals [2];
    vals[0] = 16'h0005;
    vals[1] = 16'h0000;
    lz_blank_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_idle(vals[k], 4'h0);
      enable = 1'b1;
      for (int t = 0; t <= FRAME + 2; t++) begin
        step();
        exp = ref_pins(t, vals[k], 4'h0, 1'b1);
        total_cnt++;
        if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
          $display("[TB] FAIL lz_pins v=%h t=%0d got %b want %b", vals[k], t,
                   {an_out, seg_out, dp_out, frame_tick}, exp);
        end else pass_cnt++;
      end
      enable = 1'b0;
      step();
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_random_patterns();
    logic [12:0] exp;
    logic [15:0] v;
    logic [3:0]  d;
    logic        lz;
    for (int k = 0; k < 5; k++) begin
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      d  = 4'($urandom);
      lz = 1'($urandom_range(0, 1));
      lz_blank_en = lz;
      load_idle(v, d);
      enable = 1'b1;
      for (int t = 0; t <= FRAME + 8; t++) begin
        step();
        exp = ref_pins(t, v, d, lz);
        total_cnt++;
        if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
          $display("[TB] FAIL rand_pins v=%h dp=%b lz=%b t=%0d got %b want %b", v, d, lz, t,
                   {an_out, seg_out, dp_out, frame_tick}, exp);
        end else pass_cnt++;
      end
      enable = 1'b0;
      step();
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    logic [15:0] q_v[$];
    logic [3:0]  q_d[$];
    logic [15:0] m_val, m_shv, drv_v;
    logic [3:0]  m_dp, m_shd, drv_d;
    logic        m_full, drv_valid, acc, xfer;
    m_val = 16'($urandom);
    m_dp  = 4'($urandom);
    q_v.push_back(16'($urandom)); q_d.push_back(4'($urandom));
    q_v.push_back(16'($urandom)); q_d.push_back(4'($urandom));
    m_shv = '0; m_shd = '0; m_full = 1'b0;
    lz_blank_en = 1'b0;
    load_idle(m_val, m_dp);
    enable = 1'b1;
    for (int t = 0; t <= 3 * FRAME + 4; t++) begin
      drv_valid = load_valid;
      drv_v     = value_in;
      drv_d     = dp_in;
      step();
      exp = ref_pins(t, m_val, m_dp, 1'b0);
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
        $display("[TB] FAIL b2b_pins t=%0d got %b want %b", t, {an_out, seg_out, dp_out, frame_tick}, exp);
      end else pass_cnt++;
      xfer = (t > 0) && (t % FRAME == 0) && m_full;
      acc  = drv_valid && !m_full;
      if (xfer) begin
        m_val  = m_shv;
        m_dp   = m_shd;
        m_full = 1'b0;
      end
      if (acc) begin
        m_shv  = drv_v;
        m_shd  = drv_d;
        m_full = 1'b1;
        void'(q_v.pop_front());
        void'(q_d.pop_front());
      end
      total_cnt++;
      if (load_ready !== !m_full) begin
        $display("[TB] FAIL b2b_ready t=%0d got %b want %b", t, load_ready, !m_full);
      end else pass_cnt++;
      if (t >= 10 && q_v.size() > 0) begin
        load_valid = 1'b1;
        value_in   = q_v[0];
        dp_in      = q_d[0];
      end else begin
        load_valid = 1'b0;
      end
    end
    load_valid = 1'b0;
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_enable_drop();
    logic [12:0] exp;
    logic [15:0] v1, v2;
    logic [3:0]  d1, d2;
    v1 = 16'($urandom); v2 = 16'($urandom);
    d1 = 4'($urandom);  d2 = 4'($urandom);
    lz_blank_en = 1'b0;
    load_idle(v1, d1);
    enable = 1'b1;
    for (int t = 0; t <= 21; t++) begin
      step();
      exp = ref_pins(t, v1, d1, 1'b0);
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
        $display("[TB] FAIL drop_pins t=%0d got %b want %b", t, {an_out, seg_out, dp_out, frame_tick}, exp);
      end else pass_cnt++;
      if (t == 5) begin
        load_valid = 1'b1; value_in = v2; dp_in = d2;
      end
      if (t == 6) begin
        load_valid = 1'b0;
        total_cnt++;
        if (load_ready !== 1'b0) begin
          $display("[TB] FAIL drop_pending_ready got %b want 0", load_ready);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (an_out !== 4'b1011) begin
      $display("[TB] FAIL drop_digit2 got %b want 1011", an_out);
    end else pass_cnt++;
    enable = 1'b0;
    step();
    total_cnt++;
    if ({an_out, seg_out, dp_out, frame_tick, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      $display("[TB] FAIL drop_off got %b want %b", {an_out, seg_out, dp_out, frame_tick, load_ready},
               {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end else pass_cnt++;
    step();
    step();
    enable = 1'b1;
    for (int t = 0; t <= FRAME + 2; t++) begin
      step();
      exp = ref_pins(t, v2, d2, 1'b0);
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
        $display("[TB] FAIL reenable_pins t=%0d got %b want %b", t, {an_out, seg_out, dp_out, frame_tick}, exp);
      end else pass_cnt++;
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    logic [12:0] exp;
    logic [15:0] v;
    logic [3:0]  d;
    v = 16'($urandom) | 16'h1111;
    d = 4'($urandom);
    lz_blank_en = 1'b0;
    load_idle(v, d);
    enable = 1'b1;
    for (int t = 0; t <= 12; t++) begin
      step();
      exp = ref_pins(t, v, d, 1'b0);
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick} !== exp) begin
        $display("[TB] FAIL arst_pre_pins t=%0d got %b want %b", t, {an_out, seg_out, dp_out, frame_tick}, exp);
      end else pass_cnt++;
      if (t == 3) begin
        load_valid = 1'b1; value_in = ~v; dp_in = ~d;
      end
      if (t == 4) load_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({an_out, seg_out, dp_out, frame_tick, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      $display("[TB] FAIL arst_immediate got %b want %b", {an_out, seg_out, dp_out, frame_tick, load_ready},
               {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end else pass_cnt++;
    step();
    rst_n = 1'b1;
    for (int t = 0; t <= 2 * FRAME + 4; t++) begin
      step();
      exp = ref_pins(t, 16'h0000, 4'h0, 1'b0);
      total_cnt++;
      if ({an_out, seg_out, dp_out, frame_tick, load_ready} !== {exp, 1'b1}) begin
        $display("[TB] FAIL arst_cleared t=%0d got %b want %b", t,
                 {an_out, seg_out, dp_out, frame_tick, load_ready}, {exp, 1'b1});
      end else pass_cnt++;
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    test_reset();
    test_hex_pattern();
    test_lz_blank();
    test_random_patterns();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
